note_clock_gen: RTL and testbench

- Parametrised tempo/note-duration timer for the synth sequencer. Successor to the fixed two-tempo note timer.
- Supports a runtime-programmable BPM and a subdivision-based note length. The tick period is computed by an on-block iterative divider, so no combinational divide is needed.
- Emits `playNext` at each note boundary, plus subdivision and beat strobes for the metronome/LED logic. Supports pause and resync.

---
 rtl/note_clock_gen.sv | 157 +++++++++++++++
 tb/tb_note_clock_gen.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_clock_gen.sv
// note_clock_gen: tempo and note-duration timer for the synth sequencer.
// The tick period is floor(CLK_HZ*60/SUBDIV / bpm), clamped to at least 2.
// A 32-cycle restoring divider computes it after each tempo load.
// The counter chain then produces registered sub_tick, beat and playNext strobes.
module note_clock_gen #(
  parameter int CLK_HZ = 50000000,
  parameter int BPM_W  = 9,
  parameter int LEN_W  = 4,
  parameter int SUBDIV = 4
) (
  input  logic             CLOCK_50,
  input  logic             resetn,
  input  logic             run,
  input  logic             restart,
  input  logic             tempo_load,
  input  logic [BPM_W-1:0] bpm,
  input  logic [LEN_W-1:0] length,
  output logic             playNext,
  output logic             sub_tick,
  output logic             beat,
  output logic             busy,
  output logic             bpm_err
);

  localparam int SUB_W = (SUBDIV > 1) ? $clog2(SUBDIV) : 1;
  localparam logic [31:0] NUM = 32'(64'(CLK_HZ) * 64'd60 / 64'(SUBDIV));
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SUBDIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [31:0]      quo, rem, divisor, period, tick;
  logic [4:0]       div_cnt;
  logic [SUB_W-1:0] sub_cnt;
  logic [LEN_W-1:0] note_cnt, cur_len;
  logic             ran;
  logic             load_ok, div_done, div_fin, counting, tick_end, note_end;
  logic [32:0]      rem_sh;
  logic             rem_ge;
  logic [31:0]      rem_nx, quo_nx;

  // Never let the period drop below 2 ticks, so tick==period-1 stays meaningful.
  function automatic logic [31:0] clamp_period(input logic [31:0] q);
    return (q < 32'd2) ? 32'd2 : q;
  endfunction

  assign load_ok  = tempo_load && (bpm != '0);
  assign div_done = (state == DIV) && (div_cnt == 5'd31);
  assign div_fin  = div_done && !load_ok;
  assign counting = (state == RUN) && run && !restart && !load_ok;
  assign tick_end = (tick == period - 32'd1);
  assign note_end = counting && tick_end && (note_cnt == cur_len);
  assign busy     = (state == DIV);

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  assign rem_sh = {rem, quo[31]};
  assign rem_ge = (rem_sh >= {1'b0, divisor});
  assign rem_nx = rem_ge ? (rem_sh[31:0] - divisor) : rem_sh[31:0];
  assign quo_nx = {quo[30:0], rem_ge};

  // State register.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  // Next state: a valid load always (re)starts the division; the last step enters RUN.
  always_comb begin
    state_nx = state;
    if (load_ok)       state_nx = DIV;
    else if (div_done) state_nx = RUN;
  end

  // Iterative divider; quo starts as the dividend and ends as the quotient.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      quo     <= '0;
      rem     <= '0;
      divisor <= '0;
      div_cnt <= '0;
      period  <= '0;
      ran     <= 1'b0;
    end else if (load_ok) begin
      quo     <= NUM;
      rem     <= '0;
      divisor <= {{(32-BPM_W){1'b0}}, bpm};
      div_cnt <= '0;
    end else if (state == DIV) begin
      quo     <= quo_nx;
      rem     <= rem_nx;
      div_cnt <= div_cnt + 5'd1;
      if (div_cnt == 5'd31) begin
        period <= clamp_period(quo_nx);
        ran    <= 1'b1;
      end
    end
  end

  // Sticky tempo error: set by a zero-bpm load, cleared by any valid load.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn)         bpm_err <= 1'b0;
    else if (tempo_load) bpm_err <= (bpm == '0);
  end

  // Tick/subdivision/note counters and their registered single-cycle strobes.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      tick     <= '0;
      sub_cnt  <= '0;
      note_cnt <= '0;
      playNext <= 1'b0;
      sub_tick <= 1'b0;
      beat     <= 1'b0;
    end else begin
      playNext <= 1'b0;
      sub_tick <= 1'b0;
      beat     <= 1'b0;
      if (restart) begin
        tick     <= '0;
        sub_cnt  <= '0;
        note_cnt <= '0;
      end else if (load_ok) begin
        // Note position survives a tempo change; only the tick phase restarts.
        tick <= '0;
      end else if (div_fin && !ran) begin
        tick     <= '0;
        sub_cnt  <= '0;
        note_cnt <= '0;
      end else if (counting) begin
        if (tick_end) begin
          tick     <= '0;
          sub_tick <= 1'b1;
          beat     <= (sub_cnt == SUB_LAST);
          sub_cnt  <= (sub_cnt == SUB_LAST) ? '0 : sub_cnt + SUB_W'(1);
          playNext <= (note_cnt == cur_len);
          note_cnt <= (note_cnt == cur_len) ? '0 : note_cnt + LEN_W'(1);
        end else begin
          tick <= tick + 32'd1;
        end
      end
    end
  end

  // Note length is captured only at note starts, so mid-note edits wait for the next note.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn)                        cur_len <= '0;
    else if (restart && state == RUN)   cur_len <= length;
    else if (div_fin && !ran)           cur_len <= length;
    else if (note_end)                  cur_len <= length;
  end

endmodule

// File: tb/tb_note_clock_gen.sv
// tb_note_clock_gen: randomized bench for note_clock_gen with a queue-based scoreboard.
module tb_note_clock_gen;

  localparam int CLK_HZ = 1200;
  localparam int BPM_W  = 9;
  localparam int LEN_W  = 4;
  localparam int SUBDIV = 4;
  localparam int NUM    = CLK_HZ * 60 / SUBDIV;

  logic             CLOCK_50 = 1'b0;
  logic             resetn = 1'b0;
  logic             run = 1'b0;
  logic             restart = 1'b0;
  logic             tempo_load = 1'b0;
  logic [BPM_W-1:0] bpm = '0;
  logic [LEN_W-1:0] length = '0;
  logic             playNext, sub_tick, beat, busy, bpm_err;

  note_clock_gen #(
    .CLK_HZ(CLK_HZ), .BPM_W(BPM_W), .LEN_W(LEN_W), .SUBDIV(SUBDIV)
  ) dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .run(run), .restart(restart),
    .tempo_load(tempo_load), .bpm(bpm), .length(length),
    .playNext(playNext), .sub_tick(sub_tick), .beat(beat),
    .busy(busy), .bpm_err(bpm_err)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Expected output event: cycle number and {playNext, sub_tick, beat, busy, bpm_err}.
  typedef struct packed {
    logic [31:0] cyc;
    logic [4:0]  v;
  } ev_t;
  ev_t exp_q[$];
  bit  mon_en = 1'b0;

  // Reference model state: mode 0 idle, 1 dividing, 2 running.
  int m_mode, m_left, m_pend, m_period, m_phase, m_sub, m_note, m_len;
  bit m_ran, m_err, m_pbusy, m_perr;

  bit r_run = 1'b0;
  int r_len = 0;

  task automatic model_reset();
    m_mode = 0; m_left = 0; m_pend = 0; m_period = 0;
    m_phase = 0; m_sub = 0; m_note = 0; m_len = 0;
    m_ran = 0; m_err = 0; m_pbusy = 0; m_perr = 0;
  endtask

  // Advance the model by one clock given this cycle's inputs; queue any visible output change.
  task automatic model_step(input bit ld, input int b, input bit rs, input bit rn, input int len);
    bit p, s, bt, ldok, done, nbusy;
    ev_t e;
    p = 0; s = 0; bt = 0;
    ldok = ld && (b != 0);
    done = (m_mode == 1) && (m_left == 1) && !ldok;
    if (ld) m_err = (b == 0);
    if (rs) begin
      m_phase = 0; m_sub = 0; m_note = 0;
      if (m_mode == 2) m_len = len;
    end else if (ldok) begin
      m_phase = 0;
    end else if (m_mode == 2 && rn) begin
      m_phase++;
      if (m_phase == m_period) begin
        m_phase = 0;
        s  = 1;
        bt = (m_sub == SUBDIV - 1);
        m_sub = (m_sub + 1) % SUBDIV;
        if (m_note == m_len) begin
          p = 1; m_note = 0; m_len = len;
        end else begin
          m_note++;
        end
      end
    end
    if (done && !m_ran) m_len = len;
    if (ldok) begin
      m_mode = 1; m_left = 32;
      m_pend = (NUM / b < 2) ? 2 : NUM / b;
    end else if (m_mode == 1) begin
      m_left--;
      if (m_left == 0) begin
        m_mode = 2; m_period = m_pend; m_ran = 1;
      end
    end
    nbusy = (m_mode == 1);
    if (p || s || bt || nbusy != m_pbusy || m_err != m_perr) begin
      e.cyc = 32'(cyc + 1);
      e.v   = {p, s, bt, nbusy, m_err};
      exp_q.push_back(e);
    end
    m_pbusy = nbusy;
    m_perr  = m_err;
  endtask

  task automatic step(input bit ld, input int b, input bit rs);
    @(posedge CLOCK_50);
    #1;
    tempo_load = ld;
    bpm        = BPM_W'(b);
    restart    = rs;
    run        = r_run;
    length     = LEN_W'(r_len);
    model_step(ld, b, rs, r_run, r_len);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 0, 1'b0);
  endtask

  task automatic async_reset(input string tag);
    @(posedge CLOCK_50);
    #2;
    resetn = 1'b0; tempo_load = 1'b0; restart = 1'b0;
    #1;
    checks++;
    if ({playNext, sub_tick, beat, busy, bpm_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_%s outputs=%b expected 00000", tag,
               {playNext, sub_tick, beat, busy, bpm_err});
    end
    while (exp_q.size() > 0 && int'(exp_q[0].cyc) < cyc) begin
      checks++; errors++;
      $display("FAIL missed_event cycle %0d expected %b before reset", exp_q[0].cyc, exp_q[0].v);
      void'(exp_q.pop_front());
    end
    exp_q.delete();
    model_reset();
    repeat (2) @(posedge CLOCK_50);
    #2;
    resetn = 1'b1;
  endtask

  // Monitor: whenever the DUT pulses or changes busy/bpm_err, match it against the queue head.
  initial begin
    logic [4:0] got;
    logic       pb, pe;
    ev_t        e;
    pb = 1'b0; pe = 1'b0;
    forever begin
      @(negedge CLOCK_50);
      got = {playNext, sub_tick, beat, busy, bpm_err};
      if (resetn && mon_en && (got[4:2] != 3'b0 || busy != pb || bpm_err != pe)) begin
        while (exp_q.size() > 0 && int'(exp_q[0].cyc) < cyc) begin
          checks++; errors++;
          $display("FAIL missed_event cycle %0d expected %b was not observed", exp_q[0].cyc, exp_q[0].v);
          void'(exp_q.pop_front());
        end
        checks++;
        if (exp_q.size() == 0 || int'(exp_q[0].cyc) != cyc) begin
          errors++;
          $display("FAIL unexpected_output cycle %0d got %b, no change expected", cyc, got);
        end else begin
          e = exp_q.pop_front();
          if (e.v !== got) begin
            errors++;
            $display("FAIL outputs cycle %0d got %b expected %b", cyc, got, e.v);
          end
        end
      end
      pb = busy;
      pe = bpm_err;
    end
  end

  initial begin
    model_reset();
    r_run = 1'b1; r_len = 3;
    run = 1'b1; length = 4'd3;
    repeat (3) @(posedge CLOCK_50);
    #1;
    checks++;
    if ({playNext, sub_tick, beat, busy, bpm_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_initial outputs=%b expected 00000",
               {playNext, sub_tick, beat, busy, bpm_err});
    end
    #1;
    resetn = 1'b1;
    mon_en = 1'b1;

    // No load yet: nothing may happen even with run high.
    idle(1000);

    // 120 BPM, length 3: period 150, notes of 600.
    step(1'b1, 120, 1'b0);
    idle(2500);

    // Length 0, then a mid-note switch to 7.
    r_len = 0;
    idle(700);
    r_len = 7;
    idle(2600);

    // Pause for 100 cycles mid-note.
    r_run = 1'b0;
    idle(100);
    r_run = 1'b1;
    idle(1500);

    // Zero bpm: error flag only.
    step(1'b1, 0, 1'b0);
    idle(300);

    // 240 BPM mid-note: error clears, period 75, position kept.
    idle(37);
    step(1'b1, 240, 1'b0);
    idle(1500);

    // Restarts at arbitrary points with fresh lengths.
    for (int i = 0; i < 6; i++) begin
      idle($urandom_range(20, 400));
      r_len = $urandom_range(0, 7);
      step(1'b0, 0, 1'b1);
    end
    idle(1000);

    // Async reset during a division, then during a running note.
    step(1'b1, 200, 1'b0);
    idle(10);
    async_reset("mid_div");
    step(1'b1, 150, 1'b0);
    idle(900);
    async_reset("mid_note");

    // Randomized traffic.
    r_len = 2;
    step(1'b1, 100, 1'b0);
    for (int i = 0; i < 30000; i++) begin
      int r;
      int b;
      r = $urandom_range(0, 999);
      if ($urandom_range(0, 199) == 0) r_run = !r_run;
      if ($urandom_range(0, 99) == 0) r_len = $urandom_range(0, 15);
      if (r < 2) begin
        b = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(20, 511);
        step(1'b1, b, ($urandom_range(0, 3) == 0));
      end else if (r < 5) begin
        step(1'b0, 0, 1'b1);
      end else begin
        step(1'b0, 0, 1'b0);
      end
    end

    // Quiesce and confirm every expected event was observed.
    r_run = 1'b0;
    idle(5);
    repeat (2) @(negedge CLOCK_50);
    mon_en = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drained pending=%0d expected 0 (first at cycle %0d)",
               exp_q.size(), exp_q[0].cyc);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
